mesm6_panel_ctl: RTL



---
 rtl/mesm6_panel_ctl.sv | 133 +++++++++++++
 1 files changed

// File: rtl/mesm6_panel_ctl.sv
// rtl/mesm6_panel_ctl.sv - MESM-6 front-panel control sequencer
// Turns debounced button presses into CPU reset, run/halt and single-step actions.
module mesm6_panel_ctl #(
  parameter int RST_CYCLES   = 16,
  parameter int STOP_TIMEOUT = 1024
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] sw,
  input  logic       cpu_idle,
  input  logic       cpu_stop,
  input  logic       step_ack,
  output logic       cpu_reset,
  output logic       cpu_run,
  output logic       step_req,
  output logic [5:0] panel_data,
  output logic       led_run,
  output logic       led_halt,
  output logic       stop_err
);

  localparam int CNT_MAX = (RST_CYCLES > STOP_TIMEOUT) ? RST_CYCLES : STOP_TIMEOUT;
  localparam int CW      = $clog2(CNT_MAX) + 1;
  localparam logic [CW-1:0] RST_LAST  = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] STOP_LAST = CW'(STOP_TIMEOUT - 1);

  localparam logic [2:0] S_RESET_HOLD = 3'd0;
  localparam logic [2:0] S_HALTED     = 3'd1;
  localparam logic [2:0] S_RUNNING    = 3'd2;
  localparam logic [2:0] S_STOPPING   = 3'd3;
  localparam logic [2:0] S_STEP_REQ   = 3'd4;
  localparam logic [2:0] S_STEP_WAIT  = 3'd5;

  logic [2:0]    state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          err_n;
  logic [3:0]    sw_q;
  logic [3:0]    press;
  logic [3:0]    sel, sel_q;

  assign press = sw[3:0] & ~sw_q;

  // One-hot winner of simultaneous presses: CLR > HALT > RUN > STEP.
  always_comb begin
    sel = 4'b0000;
    if (press[3])      sel = 4'b1000;
    else if (press[1]) sel = 4'b0010;
    else if (press[0]) sel = 4'b0001;
    else if (press[2]) sel = 4'b0100;
  end

  // Presses are registered so no output has a combinational path from sw.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sw_q       <= 4'b1111;
      sel_q      <= 4'b0000;
      panel_data <= 6'd0;
    end else begin
      sw_q  <= sw[3:0];
      sel_q <= sel;
      if (|press) panel_data <= sw[9:4];
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    err_n   = stop_err;
    if (state != S_RESET_HOLD && sel_q[3]) begin
      state_n = S_RESET_HOLD;
      cnt_n   = '0;
      err_n   = 1'b0;
    end else begin
      case (state)
        S_RESET_HOLD: begin
          if (cnt == RST_LAST) begin
            state_n = S_HALTED;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt + CW'(1);
          end
        end
        S_HALTED: begin
          if (sel_q[0])      state_n = S_RUNNING;
          else if (sel_q[2]) state_n = S_STEP_REQ;
        end
        S_RUNNING: begin
          if (cpu_stop) begin
            state_n = S_HALTED;
          end else if (sel_q[1]) begin
            state_n = S_STOPPING;
            cnt_n   = '0;
          end
        end
        S_STOPPING: begin
          if (cpu_idle) begin
            state_n = S_HALTED;
          end else if (cnt == STOP_LAST) begin
            state_n = S_HALTED;
            err_n   = 1'b1;
          end else begin
            cnt_n = cnt + CW'(1);
          end
        end
        S_STEP_REQ:  if (step_ack)  state_n = S_STEP_WAIT;
        S_STEP_WAIT: if (!step_ack) state_n = S_HALTED;
        default: begin
          state_n = S_RESET_HOLD;
          cnt_n   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_RESET_HOLD;
      cnt      <= '0;
      stop_err <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      stop_err <= err_n;
    end
  end

  assign cpu_reset = (state == S_RESET_HOLD);
  assign cpu_run   = (state == S_RUNNING);
  assign led_run   = (state == S_RUNNING);
  assign led_halt  = (state == S_HALTED);
  assign step_req  = (state == S_STEP_REQ);

endmodule
